ppu_palette_lookup: RTL

Upstream neighbour of the PPU composite video generator. Once per dot it merges the background and sprite pixel streams into one colour by priority, looks the result up in the 32-entry palette RAM, and applies greyscale. It hands the composite stage a registered 6-bit NES colour, split into hue and luma, together with the emphasis bits. It also owns sprite-zero-hit detection and the CPU-side palette read/write port.

---
 rtl/ppu_palette_lookup.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ppu_palette_lookup.sv
// ppu_palette_lookup
//   Merges the background and sprite pixels of a dot by priority, looks the
//   winner up in the 32-entry palette RAM and applies greyscale. The composite
//   stage receives a registered colour (split into hue/luma) plus emphasis.
//   Also tracks sprite-zero hit and serves the CPU palette read/write port.
//
// Ports
//   CLK, RST         clock, async active-low reset
//   DOT_EN           one-CLK strobe per dot; pipeline and SPR0_HIT advance on it
//   PIX_VALID        dot is in the active picture
//   BG_PIX, SPR_PIX  {palette[1:0], pattern[1:0]} for background / sprite
//   SPR_BEHIND       sprite loses to an opaque background
//   SPR_ZERO         sprite pixel is from OAM entry 0
//   SHOW_BG/SHOW_SPR layer enables; GREYSCALE mask; EMPH {B,G,R}
//   WR_EN/WR_ADDR/WR_DATA   CPU palette write
//   RD_ADDR/RD_DATA         CPU palette read, one-CLK latency
//   COLOR_OUT/HUE/LUMA/EMPH_OUT/COLOR_VALID   dot output, 2 DOT_EN strobes late
//   SPR0_HIT/SPR0_CLR       sticky sprite-zero hit and its clear
module ppu_palette_lookup #(
    parameter int PAL_ENTRIES = 32,
    parameter int COLOR_W     = 6
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           DOT_EN,
    input  logic                           PIX_VALID,
    input  logic [3:0]                     BG_PIX,
    input  logic [3:0]                     SPR_PIX,
    input  logic                           SPR_BEHIND,
    input  logic                           SPR_ZERO,
    input  logic                           SHOW_BG,
    input  logic                           SHOW_SPR,
    input  logic                           GREYSCALE,
    input  logic [2:0]                     EMPH,
    input  logic                           WR_EN,
    input  logic [$clog2(PAL_ENTRIES)-1:0] WR_ADDR,
    input  logic [COLOR_W-1:0]             WR_DATA,
    input  logic [$clog2(PAL_ENTRIES)-1:0] RD_ADDR,
    output logic [COLOR_W-1:0]             RD_DATA,
    output logic [COLOR_W-1:0]             COLOR_OUT,
    output logic [3:0]                     HUE,
    output logic [1:0]                     LUMA,
    output logic [2:0]                     EMPH_OUT,
    output logic                           COLOR_VALID,
    output logic                           SPR0_HIT,
    input  logic                           SPR0_CLR
);

    localparam int AW     = $clog2(PAL_ENTRIES);
    localparam int STAGES = 2;

    localparam logic [COLOR_W-1:0] BLANK_COLOR = 6'h0F;
    localparam logic [COLOR_W-1:0] GREY_MASK   = 6'h30;
    localparam logic [COLOR_W-1:0] FULL_MASK   = 6'h3F;

    // Stage-1 payload travelling alongside the valid bit.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic          grey;
        logic [2:0]    emph;
    } s1_t;

    // Sprite entry 0 of each sub-palette is the shared backdrop.
    function automatic logic [AW-1:0] mirror(input logic [AW-1:0] a);
        mirror = a;
        if (a[AW-1] && (a[1:0] == 2'b00))
            mirror[AW-1] = 1'b0;
    endfunction

    logic [COLOR_W-1:0] pal [PAL_ENTRIES];
    logic [STAGES:1]    vld_pipe;
    s1_t                s1;
    logic               bg_op, spr_op;
    logic [AW-1:0]      sel_addr;
    logic [COLOR_W-1:0] lut;

    assign bg_op  = SHOW_BG  && (BG_PIX[1:0]  != 2'b00);
    assign spr_op = SHOW_SPR && (SPR_PIX[1:0] != 2'b00);

    always_comb begin
        sel_addr = '0;
        if (spr_op && !(bg_op && SPR_BEHIND))
            sel_addr = {1'b1, SPR_PIX};
        else if (bg_op)
            sel_addr = {1'b0, BG_PIX};
    end

    // Palette RAM: the lookup below samples the pre-write value, so a CPU
    // write colliding with a lookup shows up from the next dot onward.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < PAL_ENTRIES; i++)
                pal[i] <= '0;
        end else if (WR_EN) begin
            pal[mirror(WR_ADDR)] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            RD_DATA <= '0;
        else
            RD_DATA <= pal[mirror(RD_ADDR)];
    end

    assign lut = pal[mirror(s1.addr)];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_pipe  <= '0;
            s1        <= '0;
            COLOR_OUT <= BLANK_COLOR;
            EMPH_OUT  <= '0;
        end else if (DOT_EN) begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], PIX_VALID};
            s1        <= '{addr: sel_addr, grey: GREYSCALE, emph: EMPH};
            COLOR_OUT <= vld_pipe[1] ? (lut & (s1.grey ? GREY_MASK : FULL_MASK))
                                     : BLANK_COLOR;
            EMPH_OUT  <= s1.emph;
        end
    end

    assign COLOR_VALID = vld_pipe[STAGES];
    assign HUE         = COLOR_OUT[3:0];
    assign LUMA        = COLOR_OUT[5:4];

    // Clear has priority over a hit landing on the same dot.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            SPR0_HIT <= 1'b0;
        else if (DOT_EN) begin
            if (SPR0_CLR)
                SPR0_HIT <= 1'b0;
            else if (PIX_VALID && SPR_ZERO && bg_op && spr_op)
                SPR0_HIT <= 1'b1;
        end
    end

endmodule
